// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential unsigned shift-and-add multiplier around one Adder
// Produces a 2*width-bit product width cycles after an accepted START.

module Adder #(
   parameter int width = 4
) (
   input  logic [width-1:0] A,
   input  logic [width-1:0] B,
   output logic [width:0]   S
);

   assign S = {1'b0, A} + {1'b0, B};

endmodule

module shift_add_multiplier #(
   parameter int width = 4
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               START,
   input  logic [width-1:0]   A,
   input  logic [width-1:0]   B,
   output logic               BUSY,
   output logic               DONE,
   output logic [2*width-1:0] P
);

   localparam int CW = ($clog2(width) < 1) ? 1 : $clog2(width);
   localparam logic [CW-1:0] LAST_CNT = CW'(width - 1);

   typedef enum logic {
      IDLE = 1'b0,
      CALC = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [width-1:0]     mcand_q, mcand_d;
   logic [2*width-1:0]   acc_q, acc_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*width-1:0]   p_q, p_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic [width-1:0]     add_a;
   logic [width-1:0]     add_b;
   logic [width:0]       add_s;

   // Upper half of ACC is the running partial sum; add MCAND when the current multiplier bit is set.
   assign add_a = acc_q[2*width-1:width];
   assign add_b = acc_q[0] ? mcand_q : '0;

   Adder #(
      .width (width)
   ) u_adder (
      .A (add_a),
      .B (add_b),
      .S (add_s)
   );

   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (START) begin
               mcand_d = A;
               acc_d   = {{width{1'b0}}, B};
               cnt_d   = '0;
               state_d = CALC;
               busy_d  = 1'b1;
            end
         end
         CALC: begin
            // The adder carry-out becomes the new MSB as the whole accumulator shifts right.
            acc_d = {add_s, acc_q[width-1:1]};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_CNT) begin
               p_d     = acc_d;
               done_d  = 1'b1;
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         mcand_q <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         p_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign BUSY = busy_q;
   assign DONE = done_q;
   assign P    = p_q;

endmodule
